instr_encode_loader: RTL and testbench

Inverse of the main opcode decoder: accepts instruction requests (class plus fields) over a valid/ready handshake and assembles 32-bit MIPS words. Each word is written sequentially into instruction memory through an ack-terminated write port. Used by the bench/boot path to load programs without hand-assembled hex. Supports the same instruction subset the control decoder implements: R-type, addi, lw, sw, beq, j.

---
 rtl/mips_isa_pkg.sv | 33 +++
 rtl/instr_encode_loader_if.sv | 34 +++
 rtl/instr_word_encoder.sv | 57 +++++
 rtl/instr_encode_loader.sv | 124 ++++++++++++
 tb/tb_instr_encode_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: primary opcodes (also used by the control decoder), loader request
// op codes, instruction field positions, and the loader FSM state type.
package mips_isa_pkg;

  // Primary opcodes, bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Loader request classes; 6 and 7 are illegal
  localparam logic [2:0] REQ_R    = 3'd0;
  localparam logic [2:0] REQ_ADDI = 3'd1;
  localparam logic [2:0] REQ_LW   = 3'd2;
  localparam logic [2:0] REQ_SW   = 3'd3;
  localparam logic [2:0] REQ_BEQ  = 3'd4;
  localparam logic [2:0] REQ_J    = 3'd5;

  // Field LSB positions within the 32-bit instruction word
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_LSB = 0;

  typedef enum logic [0:0] {StIdle, StWrite} loader_state_e;

endpackage

// File: rtl/instr_encode_loader_if.sv
// Request and instruction-memory write bus of the encode loader.
// master: request producer and memory side; slave: the loader.
interface instr_encode_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [4:0]        req_shamt;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm, req_target,
    input  req_ready,
    input  imem_we, imem_addr, imem_wdata,
    output imem_ack
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm, req_target,
    output req_ready,
    output imem_we, imem_addr, imem_wdata,
    input  imem_ack
  );
endinterface

// File: rtl/instr_word_encoder.sv
// Combinational encoder: request class plus fields -> 32-bit MIPS word, flags illegal classes.
module instr_word_encoder
  import mips_isa_pkg::*;
(
  input  logic [2:0]  req_op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [5:0] itype_opcode;
  logic       itype;

  // Pick the opcode for the I-type classes, which all share the rs/rt/imm layout
  always_comb begin
    itype_opcode = OP_RTYPE;
    itype        = 1'b1;
    unique case (req_op_i)
      REQ_ADDI: itype_opcode = OP_ADDI;
      REQ_LW:   itype_opcode = OP_LW;
      REQ_SW:   itype_opcode = OP_SW;
      REQ_BEQ:  itype_opcode = OP_BEQ;
      default:  itype        = 1'b0;
    endcase
  end

  // Assemble the word; illegal classes produce zero
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    if (itype) begin
      word_o[OPCODE_LSB +: 6] = itype_opcode;
      word_o[RS_LSB +: 5]     = rs_i;
      word_o[RT_LSB +: 5]     = rt_i;
      word_o[IMM_LSB +: 16]   = imm_i;
    end else if (req_op_i == REQ_R) begin
      word_o[OPCODE_LSB +: 6] = OP_RTYPE;
      word_o[RS_LSB +: 5]     = rs_i;
      word_o[RT_LSB +: 5]     = rt_i;
      word_o[RD_LSB +: 5]     = rd_i;
      word_o[SHAMT_LSB +: 5]  = shamt_i;
      word_o[FUNCT_LSB +: 6]  = funct_i;
    end else if (req_op_i == REQ_J) begin
      word_o[OPCODE_LSB +: 6] = OP_J;
      word_o[TARGET_LSB +: 26] = target_i;
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Instruction encode loader: accepts encode requests, writes assembled words sequentially into
// instruction memory over an ack-terminated write port, counting words until the memory is full.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  instr_encode_loader_if.slave  bus,
  input  logic                  clear,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err_illegal
);

  localparam logic [ADDR_W:0]   DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  loader_state_e     state_q, state_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              clear_pend_q, clear_pend_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;

  instr_word_encoder u_encoder (
    .req_op_i  (bus.req_op),
    .rs_i      (bus.req_rs),
    .rt_i      (bus.req_rt),
    .rd_i      (bus.req_rd),
    .shamt_i   (bus.req_shamt),
    .funct_i   (bus.req_funct),
    .imm_i     (bus.req_imm),
    .target_i  (bus.req_target),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign full          = (count_q == DepthCnt);
  // clear gates ready so a request in the clear cycle is never taken
  assign bus.req_ready = (state_q == StIdle) & ~full & ~clear;
  assign accept        = bus.req_valid & bus.req_ready;

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign count          = count_q;
  assign err_illegal    = err_q;

  // Next-state: accept/encode in idle, hold the write stable until ack
  always_comb begin
    state_d      = state_q;
    imem_we_d    = imem_we_q;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    count_d      = count_q;
    err_d        = err_q;
    clear_pend_d = clear_pend_q;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          count_d     = '0;
          imem_addr_d = BaseAddr;
          err_d       = 1'b0;
        end else if (accept) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            imem_wdata_d = enc_word;
            imem_addr_d  = BaseAddr + count_q[ADDR_W-1:0];
            imem_we_d    = 1'b1;
            state_d      = StWrite;
          end
        end
      end
      StWrite: begin
        if (clear) clear_pend_d = 1'b1;
        if (bus.imem_ack) begin
          imem_we_d = 1'b0;
          state_d   = StIdle;
          // A clear seen at any point of the write (including the ack cycle) restarts the count
          if (clear_pend_q || clear) begin
            count_d      = '0;
            err_d        = 1'b0;
            imem_addr_d  = BaseAddr;
            clear_pend_d = 1'b0;
          end else if (count_q != DepthCnt) begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with asynchronous reset; reset abandons any in-flight write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BaseAddr;
      imem_wdata_q <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      count_q      <= count_d;
      err_q        <= err_d;
      clear_pend_q <= clear_pend_d;
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: directed cases plus randomized traffic against a
// transaction-level reference model (pending write slot, word count, sticky error).
module tb_instr_encode_loader;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned BASE  = 0;

  logic         clk;
  logic         reset_n;
  logic         clear;
  logic [AW:0]  count;
  logic         full;
  logic         err_illegal;

  instr_encode_loader_if #(.ADDR_W(AW)) bus ();

  instr_encode_loader #(
    .ADDR_W    (AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .clear       (clear),
    .count       (count),
    .full        (full),
    .err_illegal (err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_pend;
  int unsigned m_addr;
  logic [31:0] m_word;
  int unsigned m_count;
  bit          m_err;
  bit          m_clrp;

  // Current request fields
  logic [2:0]  f_op;
  logic [4:0]  f_rs, f_rt, f_rd, f_sh;
  logic [5:0]  f_fn;
  logic [15:0] f_imm;
  logic [25:0] f_tgt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rs, rt, rd, sh,
                                      input logic [5:0] fn, input logic [15:0] imm,
                                      input logic [25:0] tgt);
    int unsigned opc;
    case (op)
      3'd0: return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
      3'd1: opc = 8;
      3'd2: opc = 35;
      3'd3: opc = 43;
      3'd4: opc = 4;
      3'd5: return (32'd2 << 26) | 32'(tgt);
      default: return 32'd0;
    endcase
    return (opc << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_addr = BASE; m_word = '0; m_count = 0; m_err = 0; m_clrp = 0;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [4:0] rs, rt, rd, sh,
                         input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    f_op = op; f_rs = rs; f_rt = rt; f_rd = rd; f_sh = sh; f_fn = fn; f_imm = imm; f_tgt = tgt;
  endtask

  // One cycle: drive at the falling edge, check against the model, advance the model
  task automatic step(input bit v, input bit ack, input bit clr);
    bit exp_ready;
    bus.req_valid  = v;
    bus.req_op     = f_op;
    bus.req_rs     = f_rs;
    bus.req_rt     = f_rt;
    bus.req_rd     = f_rd;
    bus.req_shamt  = f_sh;
    bus.req_funct  = f_fn;
    bus.req_imm    = f_imm;
    bus.req_target = f_tgt;
    bus.imem_ack   = ack;
    clear          = clr;
    #1;
    exp_ready = !m_pend && (m_count < DEPTH) && !clr;
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("imem_we", 32'(bus.imem_we), 32'(m_pend));
    if (m_pend) begin
      check("imem_addr", 32'(bus.imem_addr), m_addr);
      check("imem_wdata", bus.imem_wdata, m_word);
    end
    check("count", 32'(count), m_count);
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("err_illegal", 32'(err_illegal), 32'(m_err));
    if (m_pend) begin
      if (clr) m_clrp = 1;
      if (ack) begin
        m_pend = 0;
        if (m_clrp) begin
          m_count = 0; m_err = 0; m_clrp = 0;
        end else begin
          m_count++;
        end
      end
    end else if (clr) begin
      m_count = 0; m_err = 0;
    end else if (v && exp_ready) begin
      if (f_op > 3'd5) begin
        m_err = 1;
      end else begin
        m_pend = 1;
        m_addr = (BASE + m_count) % DEPTH;
        m_word = enc(f_op, f_rs, f_rt, f_rd, f_sh, f_fn, f_imm, f_tgt);
      end
    end
    @(negedge clk);
  endtask

  // Accept the current request, check the word against a hand-computed constant, ack it
  task automatic write_word(input string tag, input int unsigned exp_addr,
                            input logic [31:0] exp_word);
    step(1, 0, 0);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd1);
    check({tag, "_addr"}, 32'(bus.imem_addr), exp_addr);
    check({tag, "_wdata"}, bus.imem_wdata, exp_word);
    step(0, 1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_addr"}, 32'(bus.imem_addr), BASE);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_err"}, 32'(err_illegal), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    bus.req_valid = 1'b0;
    bus.imem_ack  = 1'b0;
    set_req(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    reset_n = 1'b1;

    // R-type, then ready returns high after a same-cycle ack
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    write_word("rtype", 0, 32'h00221820);
    check("rtype_count", 32'(count), 32'd1);
    check("rtype_ready", 32'(bus.req_ready), 32'd1);

    // Back-to-back I-type and J
    set_req(3'd1, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0007, 26'h0);
    write_word("addi", 1, 32'h20050007);
    set_req(3'd2, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0);
    write_word("lw", 2, 32'h8FA80004);
    set_req(3'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'h0);
    write_word("beq", 3, 32'h1022FFFF);
    set_req(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h10);
    write_word("j", 4, 32'h08000010);
    check("b2b_count", 32'(count), 32'd5);

    // Ack stall: write held stable for 5 cycles
    set_req(3'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010, 26'h0);
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("stall_wdata", bus.imem_wdata, 32'hAC640010);
      check("stall_addr", 32'(bus.imem_addr), 32'd5);
      step(1, 0, 0);
    end
    step(0, 1, 0);
    check("stall_count", 32'(count), 32'd6);

    // Illegal op: no write, sticky error, address unchanged for the next legal op
    set_req(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1);
    step(1, 0, 0);
    check("illegal_we", 32'(bus.imem_we), 32'd0);
    check("illegal_err", 32'(err_illegal), 32'd1);
    check("illegal_count", 32'(count), 32'd6);
    set_req(3'd0, 5'd7, 5'd8, 5'd9, 5'd2, 6'h00, 16'h0, 26'h0);
    write_word("after_illegal", 6, 32'h00E84880);
    check("illegal_sticky", 32'(err_illegal), 32'd1);

    // Fill to DEPTH, then clear (same-cycle valid ignored)
    set_req(3'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234, 26'h0);
    write_word("last", 7, 32'h20431234);
    step(1, 0, 0);
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(bus.req_ready), 32'd0);
    step(1, 0, 1);
    check("clear_count", 32'(count), 32'd0);
    check("clear_full", 32'(full), 32'd0);
    check("clear_err", 32'(err_illegal), 32'd0);
    write_word("after_clear", 0, 32'h20431234);

    // Clear during WRITE: write completes, count restarts, error clears
    set_req(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
    step(1, 0, 0);
    set_req(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF);
    step(1, 0, 0);
    check("midclr_addr", 32'(bus.imem_addr), 32'd1);
    step(0, 0, 1);
    step(0, 0, 0);
    check("midclr_we_held", 32'(bus.imem_we), 32'd1);
    step(0, 1, 0);
    check("midclr_count", 32'(count), 32'd0);
    check("midclr_err", 32'(err_illegal), 32'd0);

    // Async reset during WRITE
    set_req(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0);
    step(1, 0, 0);
    set_req(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h8000, 26'h0);
    write_word("pre_rst", 0, 32'h8C218000);
    step(1, 0, 0);
    check("pre_rst_we", 32'(bus.imem_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      set_req(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
              16'($urandom), 26'($urandom));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
